// File: rtl/alu_pkg.sv
// Shared definitions for the accumulator stage: default width, op codes, FSM states.
package alu_pkg;

  localparam int DEF_WIDTH = 4;

  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_ADD  = 2'b01;
  localparam logic [1:0] OP_SUB  = 2'b10;
  localparam logic [1:0] OP_NEG  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_COMP = 2'b01,
    ST_ADD  = 2'b10,
    ST_DONE = 2'b11
  } state_t;

endpackage

// File: rtl/alu_acc_adder.sv
// Combinational WIDTH-bit adder with carry-in, carry-out and signed overflow.
// With ALU_ACC_SAT_EN defined, an overflowing result is clamped to the most
// positive / most negative value; otherwise the sum wraps.
module alu_acc_adder #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             ovf
);

  logic [WIDTH:0]   full;
  logic [WIDTH-1:0] raw;

  // Full-width add, signed overflow from operand/result sign bits, optional clamp.
  always_comb begin
    full  = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
    raw   = full[WIDTH-1:0];
    carry = full[WIDTH];
    ovf   = (a[WIDTH-1] == b[WIDTH-1]) && (raw[WIDTH-1] != a[WIDTH-1]);
`ifdef ALU_ACC_SAT_EN
    // Both operands share a sign when ovf is set, so a's sign gives the direction.
    if (ovf) sum = a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    else     sum = raw;
`else
    sum = raw;
`endif
  end

endmodule

// File: rtl/alu_accumulator.sv
// Sequential accumulator stage in front of an external complementer.
// SUB and NEG are formed as complement + 1: the word to invert goes out on
// cmp_a during the single COMP cycle and ~cmp_a comes back on cmp_out.
// Optional feature: ALU_ACC_SAT_EN (saturating result on signed overflow).
//
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high. in_ready is high only in IDLE; res_valid is high only in DONE and
// stays high, with acc/flags frozen, until res_ready. Requests arriving while
// busy are dropped, never queued.
module alu_accumulator
  import alu_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] cmp_a,
  output logic             cmp_en,
  input  logic [WIDTH-1:0] cmp_out,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] acc,
  output logic             carry,
  output logic             ovf,
  output logic             zero,
  output state_t           dbg_state
);

  state_t           state, state_nxt;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] addend_q;
  logic             cin_q;
  logic [WIDTH-1:0] augend;
  logic [WIDTH-1:0] add_sum;
  logic             add_carry;
  logic             add_ovf;
  logic             accept;

  assign accept    = in_valid && in_ready;
  assign dbg_state = state;

  // NEG computes 0 + ~acc + 1, every other arithmetic op starts from acc.
  assign augend = (op_q == OP_NEG) ? '0 : acc;

  alu_acc_adder #(.WIDTH(WIDTH)) u_adder (
    .a     (augend),
    .b     (addend_q),
    .cin   (cin_q),
    .sum   (add_sum),
    .carry (add_carry),
    .ovf   (add_ovf)
  );

  // Next-state and complementer drive; cmp_* are decoded from state only.
  always_comb begin
    state_nxt = state;
    cmp_en    = 1'b0;
    cmp_a     = '0;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          case (op)
            OP_LOAD: state_nxt = ST_DONE;
            OP_ADD:  state_nxt = ST_ADD;
            default: state_nxt = ST_COMP;
          endcase
        end
      end
      ST_COMP: begin
        cmp_en    = 1'b1;
        cmp_a     = (op_q == OP_NEG) ? acc : b_q;
        state_nxt = ST_ADD;
      end
      ST_ADD:  state_nxt = ST_DONE;
      ST_DONE: if (res_ready) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State, handshake outputs, operand capture and accumulator/flag updates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      op_q      <= OP_LOAD;
      b_q       <= '0;
      addend_q  <= '0;
      cin_q     <= 1'b0;
      acc       <= '0;
      carry     <= 1'b0;
      ovf       <= 1'b0;
      zero      <= 1'b1;
      res_valid <= 1'b0;
      in_ready  <= 1'b0;
    end else begin
      state     <= state_nxt;
      in_ready  <= (state_nxt == ST_IDLE);
      res_valid <= (state_nxt == ST_DONE);
      case (state)
        ST_IDLE: begin
          if (accept) begin
            op_q <= op;
            b_q  <= B;
            if (op == OP_LOAD) begin
              acc   <= B;
              carry <= 1'b0;
              ovf   <= 1'b0;
              zero  <= (B == '0);
            end
            if (op == OP_ADD) begin
              addend_q <= B;
              cin_q    <= 1'b0;
            end
          end
        end
        ST_COMP: begin
          addend_q <= cmp_out;
          cin_q    <= 1'b1;
        end
        ST_ADD: begin
          acc   <= add_sum;
          carry <= add_carry;
          ovf   <= add_ovf;
          zero  <= (add_sum == '0);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_accumulator.sv
// Directed + random bench for alu_accumulator with an external complementer model.
module tb_alu_accumulator;
  import alu_pkg::*;

  localparam int W = DEF_WIDTH;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         res_ready = 1'b0;
  logic [1:0]   op = OP_LOAD;
  logic [W-1:0] b = '0;
  logic         in_ready, cmp_en, res_valid, carry, ovf, zero;
  logic [W-1:0] cmp_a, cmp_out, acc;
  state_t       dbg_state;

  int errors = 0;
  int checks = 0;
  logic [6:0]   exp_q[$];
  logic [W-1:0] m_acc = '0;

  // Clock / reset
  always #5 clk = ~clk;

  // External complementer: inverts when enabled, undefined otherwise.
  assign cmp_out = cmp_en ? ~cmp_a : 'x;

  alu_accumulator #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .B(b), .cmp_a(cmp_a), .cmp_en(cmp_en), .cmp_out(cmp_out),
    .res_valid(res_valid), .res_ready(res_ready), .acc(acc),
    .carry(carry), .ovf(ovf), .zero(zero), .dbg_state(dbg_state)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: returns {acc, carry, ovf, zero} after applying op to a.
  function automatic logic [6:0] model_step(input logic [1:0] o, input logic [3:0] bv,
                                            input logic [3:0] a);
    int sa, sb, s, u;
    logic [3:0] r;
    logic c, v;
    sa = a[3]  ? int'(a) - 16  : int'(a);
    sb = bv[3] ? int'(bv) - 16 : int'(bv);
    c = 1'b0; v = 1'b0; r = bv; s = 0;
    case (o)
      OP_ADD: begin
        u = int'(a) + int'(bv); c = (u > 15); s = sa + sb; r = 4'(u);
      end
      OP_SUB: begin
        c = (a >= bv); s = sa - sb; r = 4'(int'(a) - int'(bv));
      end
      OP_NEG: begin
        c = (a == 4'd0); s = -sa; r = 4'(16 - int'(a));
      end
      default: begin
        r = bv; s = sb;
      end
    endcase
    if (o != OP_LOAD) v = (s > 7) || (s < -8);
`ifdef ALU_ACC_SAT_EN
    if (v) r = (s > 7) ? 4'd7 : 4'd8;
`endif
    return {r, c, v, (r == 4'd0)};
  endfunction

  // Driver: wait (bounded) for in_ready at a negedge.
  task automatic wait_ready();
    int n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("in_ready_wait", {31'd0, in_ready}, 32'd1);
  endtask

  // Driver: one full operation, checking latency, complementer drive and result.
  task automatic run_op(input logic [1:0] o, input logic [3:0] bv);
    logic [6:0] e;
    logic [3:0] pre_acc, exp_cmp;
    int lat, exp_lat;
    wait_ready();
    pre_acc = m_acc;
    e = model_step(o, bv, m_acc);
    exp_q.push_back(e);
    m_acc = e[6:3];
    exp_lat = (o == OP_LOAD) ? 1 : (o == OP_ADD) ? 2 : 3;
    exp_cmp = (o == OP_SUB) ? bv : (o == OP_NEG) ? pre_acc : 4'd0;
    op = o; b = bv; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    b = 4'($urandom_range(0, 15));
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        check("cmp_en_cycle1", {31'd0, cmp_en}, {31'd0, (o == OP_SUB || o == OP_NEG)});
        check("cmp_a_cycle1", {28'd0, cmp_a}, {28'd0, exp_cmp});
      end
    end while (!res_valid && lat < 10);
    check("latency", lat, exp_lat);
    check("cmp_en_done", {31'd0, cmp_en}, 32'd0);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("result", {25'd0, acc, carry, ovf, zero}, {25'd0, e});
    end
    res_ready = 1'b1;
    @(posedge clk);
    #1 res_ready = 1'b0;
    @(negedge clk);
    check("res_valid_after_hs", {31'd0, res_valid}, 32'd0);
    check("in_ready_after_hs", {31'd0, in_ready}, 32'd1);
  endtask

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [6:0] e;
    int n;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_acc", {28'd0, acc}, 32'd0);
    check("rst_flags", {29'd0, carry, ovf, zero}, 32'b001);
    check("rst_res_valid", {31'd0, res_valid}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_cmp", {27'd0, cmp_en, cmp_a}, 32'd0);
    check("rst_state", {30'd0, dbg_state}, {30'd0, ST_IDLE});
    rst_n = 1'b1;

    // Directed arithmetic cases
    run_op(OP_LOAD, 4'd5);
    run_op(OP_ADD,  4'd3);
    run_op(OP_LOAD, 4'd3);
    run_op(OP_SUB,  4'd5);
    run_op(OP_LOAD, 4'd5);
    run_op(OP_SUB,  4'd5);
    run_op(OP_LOAD, 4'd8);
    run_op(OP_NEG,  4'd6);
    run_op(OP_NEG,  4'd1);
    run_op(OP_LOAD, 4'd0);
    run_op(OP_NEG,  4'd9);
    run_op(OP_LOAD, 4'd7);
    run_op(OP_SUB,  4'd8);
    run_op(OP_LOAD, 4'd8);
    run_op(OP_ADD,  4'd8);

    // Random operations
    for (int i = 0; i < 12; i++)
      run_op(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)));

    // Backpressure: result held, busy requests ignored
    wait_ready();
    e = model_step(OP_ADD, 4'd1, m_acc);
    exp_q.push_back(e);
    m_acc = e[6:3];
    op = OP_ADD; b = 4'd1; in_valid = 1'b1;
    @(posedge clk);
    #1 op = OP_LOAD; b = 4'd9;
    n = 0;
    while (!res_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("hold_reach_done", {31'd0, res_valid}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_res_valid", {31'd0, res_valid}, 32'd1);
      check("hold_in_ready", {31'd0, in_ready}, 32'd0);
      check("hold_acc", {28'd0, acc}, {28'd0, e[6:3]});
    end
    in_valid = 1'b0;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("hold_result", {25'd0, acc, carry, ovf, zero}, {25'd0, e});
    end
    res_ready = 1'b1;
    @(posedge clk);
    #1 res_ready = 1'b0;
    @(negedge clk);
    check("hold_release_idle", {30'd0, dbg_state}, {30'd0, ST_IDLE});
    check("hold_no_second_accept", {28'd0, acc}, {28'd0, m_acc});
    run_op(OP_LOAD, 4'd9);

    // Reset during COMP of a SUB
    run_op(OP_LOAD, 4'd3);
    wait_ready();
    op = OP_SUB; b = 4'd5; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    check("mid_comp_state", {30'd0, dbg_state}, {30'd0, ST_COMP});
    check("mid_comp_cmp_a", {28'd0, cmp_a}, 32'd5);
    rst_n = 1'b0;
    #1;
    check("arst_acc", {28'd0, acc}, 32'd0);
    check("arst_res_valid", {31'd0, res_valid}, 32'd0);
    check("arst_cmp_en", {31'd0, cmp_en}, 32'd0);
    check("arst_in_ready", {31'd0, in_ready}, 32'd0);
    check("arst_zero", {31'd0, zero}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    m_acc = '0;
    run_op(OP_LOAD, 4'd2);

    // Final report
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
